// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   REG_ADDR_W / REG_DATA_W : register address and data widths
//   ZERO_REG                : hard-wired zero register, never written
//   wb_entry_t              : one queued writeback {reg_addr, data, stale}
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [REG_DATA_W-1:0] data;
    logic                  stale;  // overwritten by a younger primary write
  } wb_entry_t;

endpackage

// File: rtl/wb_pending_queue.sv
// FIFO for long-latency writeback results, with WAW kill and a pending-register mask.
//   clk, rst          : clock, synchronous active-high reset
//   i_push            : enqueue {i_push_reg, i_push_data} (caller guarantees !full)
//   i_pop             : dequeue head (caller guarantees !empty)
//   i_kill/i_kill_reg : primary write this edge; marks older matching entries stale
//   o_ready           : registered !full
//   o_empty           : queue holds no entries
//   o_head            : current head entry
//   o_pending_mask    : one-hot OR of live resident destination registers, bit 0 forced low
module wb_pending_queue
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [REG_ADDR_W-1:0] i_push_reg,
  input  logic [REG_DATA_W-1:0] i_push_data,
  input  logic                  i_pop,
  input  logic                  i_kill,
  input  logic [REG_ADDR_W-1:0] i_kill_reg,
  output logic                  o_ready,
  output logic                  o_empty,
  output wb_entry_t             o_head,
  output logic [31:0]           o_pending_mask
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW:0]   r_count;
  logic            r_ready;

  logic [PtrW:0]   w_count_d;
  logic [DEPTH-1:0] w_resident;
  logic [31:0]     w_mask;

  assign w_count_d = r_count + (PtrW+1)'(i_push) - (PtrW+1)'(i_pop);

  // A slot is resident when its distance from the read pointer is below the occupancy.
  always_comb begin
    w_resident = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PtrW-1:0] w_off;
      w_off = PtrW'(i) - r_rd_ptr;
      w_resident[i] = ({1'b0, w_off} < r_count);
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_resident[i] && !r_mem[i].stale) begin
        w_mask[r_mem[i].reg_addr] = 1'b1;
      end
    end
    w_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i].stale <= 1'b0;
      end
    end else begin
      // Kill only entries resident before this edge; the slot being pushed is never resident.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && w_resident[i] && (r_mem[i].reg_addr == i_kill_reg)) begin
          r_mem[i].stale <= 1'b1;
        end
      end
      if (i_push) begin
        r_mem[r_wr_ptr] <= '{reg_addr: i_push_reg, data: i_push_data, stale: 1'b0};
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= w_count_d;
      r_ready <= (w_count_d != (PtrW+1)'(DEPTH));
    end
  end

  assign o_ready        = r_ready;
  assign o_empty        = (r_count == '0);
  assign o_head         = r_mem[r_rd_ptr];
  assign o_pending_mask = w_mask;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Front end for the register file's single write port. The pipeline writeback always wins;
// buffered long-latency results drain in idle writeback cycles.
//   clk, rst                        : clock, synchronous active-high reset
//   wb_valid/wb_reg/wb_data         : pipeline writeback, never stalled
//   sec_valid/sec_ready/sec_reg/sec_data : long-latency result handshake
//   RegWrite/Write_register/Write_data   : registered register-file write port
//   pending_mask                    : registers with live queued writes (for ID stall)
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [ADDR_W-1:0] sec_reg,
  input  logic [DATA_W-1:0] sec_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_register,
  output logic [DATA_W-1:0] Write_data,
  output logic [31:0]       pending_mask
);

  logic              w_wb_write;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  wb_entry_t         w_head;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_register;
  logic [DATA_W-1:0] r_write_data;

  assign w_wb_write = wb_valid && (wb_reg != ZERO_REG);
  // $0 transfers still complete the handshake but are dropped.
  assign w_push     = sec_valid && sec_ready && (sec_reg != ZERO_REG);
  assign w_pop      = !w_wb_write && !w_empty;

  wb_pending_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_push_reg    (sec_reg),
    .i_push_data   (sec_data),
    .i_pop         (w_pop),
    .i_kill        (w_wb_write),
    .i_kill_reg    (wb_reg),
    .o_ready       (sec_ready),
    .o_empty       (w_empty),
    .o_head        (w_head),
    .o_pending_mask(pending_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
    end else if (w_wb_write) begin
      r_reg_write      <= 1'b1;
      r_write_register <= wb_reg;
      r_write_data     <= wb_data;
    end else if (w_pop && !w_head.stale) begin
      r_reg_write      <= 1'b1;
      r_write_register <= w_head.reg_addr;
      r_write_data     <= w_head.data;
    end else begin
      // Idle or a stale head popped silently.
      r_reg_write <= 1'b0;
    end
  end

  assign RegWrite       = r_reg_write;
  assign Write_register = r_write_register;
  assign Write_data     = r_write_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_reg;
  logic [31:0] sec_data;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;

  // Expected register-file writes {reg, data}, in order.
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DEPTH (4),
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .sec_valid     (sec_valid),
    .sec_ready     (sec_ready),
    .sec_reg       (sec_reg),
    .sec_data      (sec_data),
    .RegWrite      (RegWrite),
    .Write_register(Write_register),
    .Write_data    (Write_data),
    .pending_mask  (pending_mask)
  );

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (RegWrite === 1'b1) begin
      logic [36:0] exp_w;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got reg=%0d data=%h, required no write", Write_register,
                 Write_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({Write_register, Write_data} !== exp_w) begin
          errors++;
          $display("FAIL write_value: got reg=%0d data=%h, required reg=%0d data=%h",
                   Write_register, Write_data, exp_w[36:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    sec_valid = 1'b0; sec_reg = '0; sec_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_regwrite", 32'(RegWrite), 32'd0);
    check("reset_wreg", 32'(Write_register), 32'd0);
    check("reset_wdata", Write_data, 32'd0);
    check("reset_mask", pending_mask, 32'd0);
    check("reset_ready", 32'(sec_ready), 32'd1);

    // Primary write, one-cycle latency.
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
    expect_write(5'd5, 32'h1234);
    tick();
    wb_valid = 1'b0;
    check("prim_regwrite", 32'(RegWrite), 32'd1);
    tick();
    check("prim_idle", 32'(RegWrite), 32'd0);

    // Fill the queue while the pipeline holds the write port.
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 32'(sec_ready), 32'd1);
      wb_valid = 1'b1; wb_reg = 5'd31; wb_data = 32'h1000 + 32'(i);
      sec_valid = 1'b1; sec_reg = 5'(i + 1); sec_data = 32'hA0 + 32'(i);
      expect_write(5'd31, 32'h1000 + 32'(i));
      tick();
    end
    sec_valid = 1'b0;
    check("full_ready", 32'(sec_ready), 32'd0);
    check("full_mask", pending_mask, 32'h1E);
    wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) expect_write(5'(i + 1), 32'hA0 + 32'(i));
    tick();
    check("drain_ready", 32'(sec_ready), 32'd1);
    check("drain_mask1", pending_mask, 32'h1C);
    tick(); tick(); tick();
    check("drain_mask_end", pending_mask, 32'd0);
    tick();
    check("drain_idle", 32'(RegWrite), 32'd0);

    // Kill: queued write to r7 superseded by a pipeline write to r7.
    sec_valid = 1'b1; sec_reg = 5'd7; sec_data = 32'hAAAA;
    tick();
    sec_valid = 1'b0;
    check("kill_mask_before", pending_mask, 32'h80);
    wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hBBBB;
    expect_write(5'd7, 32'hBBBB);
    tick();
    wb_valid = 1'b0;
    check("kill_mask_after", pending_mask, 32'd0);
    tick();
    check("kill_pop_silent", 32'(RegWrite), 32'd0);
    check("kill_empty_ready", 32'(sec_ready), 32'd1);

    // Same edge to r9: pipeline first, then the younger queued value.
    wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'hCCCC;
    sec_valid = 1'b1; sec_reg = 5'd9; sec_data = 32'hDDDD;
    expect_write(5'd9, 32'hCCCC);
    expect_write(5'd9, 32'hDDDD);
    tick();
    wb_valid = 1'b0; sec_valid = 1'b0;
    check("same_edge_mask", pending_mask, 32'h200);
    tick();
    check("same_edge_second", 32'(RegWrite), 32'd1);
    tick();

    // $0 on both paths: handshake completes, nothing written or queued.
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hDEAD;
    sec_valid = 1'b1; sec_reg = 5'd0; sec_data = 32'hBEEF;
    tick();
    wb_valid = 1'b0; sec_valid = 1'b0;
    check("zero_regwrite", 32'(RegWrite), 32'd0);
    check("zero_mask", pending_mask, 32'd0);
    check("zero_ready", 32'(sec_ready), 32'd1);
    tick();
    check("zero_no_pop", 32'(RegWrite), 32'd0);

    // Reset with three entries queued discards them.
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_reg = 5'd31; wb_data = 32'h2000 + 32'(i);
      sec_valid = 1'b1; sec_reg = 5'(10 + i); sec_data = 32'h3000 + 32'(i);
      expect_write(5'd31, 32'h2000 + 32'(i));
      tick();
    end
    wb_valid = 1'b0; sec_valid = 1'b0;
    check("pre_rst_mask", pending_mask, 32'h1C00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_mask", pending_mask, 32'd0);
    check("rst_ready", 32'(sec_ready), 32'd1);
    check("rst_wreg", 32'(Write_register), 32'd0);
    tick();
    check("post_rst_regwrite", 32'(RegWrite), 32'd0);
    tick();
    check("post_rst_idle", 32'(RegWrite), 32'd0);

    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Writer-side front end for the 32x32 register file's single write port (RegWrite / Write_register / Write_data).
- Merges two writeback sources:
  - the in-order pipeline writeback, which is never stalled;
  - a long-latency result source (mul/div/cp0 read path), accepted by valid/ready and buffered in a small queue.
- Exports a pending-write mask so ID can stall on registers whose queued results have not yet been written.

Parameters:
- DEPTH, 4, secondary queue entries; power of two, >= 2.
- DATA_W, 32, data width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_valid  in  1  pipeline writeback valid; always accepted.
- wb_reg  in  ADDR_W  pipeline destination register.
- wb_data  in  DATA_W  pipeline result.
- sec_valid  in  1  secondary result valid.
- sec_ready  out  1  secondary accept; transfer occurs when sec_valid && sec_ready.
- sec_reg  in  ADDR_W  secondary destination register.
- sec_data  in  DATA_W  secondary result.
- RegWrite  out  1  register-file write enable (registered).
- Write_register  out  ADDR_W  register-file write address (registered).
- Write_data  out  DATA_W  register-file write data (registered).
- pending_mask  out  32  bit r set while a live queued write to r exists.

Behaviour:
- Reset (rst high at the clock edge):
  - next cycle: RegWrite=0, Write_register=0, Write_data=0, pending_mask=0, sec_ready=1;
  - queue emptied and all stale bits cleared;
  - applies mid-operation: any in-flight queued writes are lost.
- Writes to $0:
  - wb_reg==0 → no output write, no kill;
  - secondary transfer with sec_reg==0 → handshake completes, nothing enqueued.
- Primary path, 1-cycle latency:
  - wb_valid at edge t (wb_reg!=0) → RegWrite=1 during cycle t+1, with Write_register=wb_reg and Write_data=wb_data.
- Queue:
  - FIFO of {reg, data, stale}; sec_ready = !full, registered from the occupancy count;
  - no pass-through; enqueue and dequeue in the same cycle are allowed;
  - a full queue that dequeues this cycle still shows sec_ready=0 this cycle.
- Dequeue:
  - occurs only in cycles with wb_valid low (or wb_reg==0) and queue non-empty;
  - head non-stale → issued as the next-cycle write;
  - head stale → popped silently, RegWrite=0 next cycle.
  - Minimum secondary latency: enqueue at edge t, write visible in cycle t+2.
- Kill (WAW ordering):
  - a primary write to r at edge t sets stale on every entry resident before t whose reg==r;
  - an entry enqueued at the same edge is younger and is not killed.
- Same-register entries: multiple live entries to one r issue in FIFO order, so the youngest wins.
- pending_mask:
  - combinational OR of one-hot(reg) over resident, non-stale entries, with bit 0 forced to 0;
  - an entry's bit clears in the cycle after it is dequeued (when its RegWrite is high);
  - the register file's own write bypass covers that cycle.
- Pointers: read and write pointers wrap modulo DEPTH; occupancy count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG=5'd0;
  - writeback-entry struct {reg, data, stale}.
- One sub-module, wb_pending_queue:
  - holds the FIFO storage, pointers and count;
  - does the per-entry kill compare and generates pending_mask.
- Top level: priority select and the output register stage.

Test Plan:
- Reset then idle → RegWrite=0, pending_mask=0, sec_ready=1.
- wb_valid with reg 5, data 32'h1234 → cycle+1: RegWrite=1, Write_register=5, Write_data=32'h1234.
- Four sec transfers (regs 1,2,3,4) while wb_valid is held high:
  - sec_ready=0 after the 4th, pending_mask=32'h1E;
  - drop wb_valid → writes 1,2,3,4 on consecutive cycles; mask ends at 0.
- Queue sec reg 7 (data A), then a wb write to reg 7 (data B) → only B is written; pending_mask[7] clears the cycle after the kill; the queue pop produces RegWrite=0.
- Same edge: wb reg 9 (data C) and sec reg 9 (data D) → C written first, then D (not stale).
- sec_reg=0 and wb_reg=0 → no RegWrite, mask unchanged; rst asserted with 3 entries queued → next cycle empty, mask=0, no writes.
